// File: rtl/ita_package.sv
// Shared definitions for the ITA output writeback path.
//
// Contents:
//   OupN, OupM, OupAddrWidth : default lane count, tile edge and address width
//   oup_req_t                : one memory write request {addr, data, strb}
//   oup_wr_state_e           : writer FSM states
package ita_package;

   localparam int unsigned OupN         = 16;
   localparam int unsigned OupM         = 64;
   localparam int unsigned OupAddrWidth = 32;

   typedef struct packed {
      logic [OupAddrWidth-1:0] addr;
      logic [OupN*8-1:0]       data;
      logic [OupN-1:0]         strb;
   } oup_req_t;

   typedef enum logic [1:0] {
      Idle  = 2'd0,
      Run   = 2'd1,
      Drain = 2'd2,
      Done  = 2'd3
   } oup_wr_state_e;

endpackage

// File: rtl/ita_oup_skid.sv
// Two-entry skid buffer with registered outputs and a registered ready.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. valid never waits for ready, and once
// valid is raised the payload holds until the transfer.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  upstream handshake, in_ready_o is a flop output
//   in_data_i              upstream payload
//   out_valid_o/out_ready_i downstream handshake, out_* are flop outputs
//   out_data_o             downstream payload
//   count_o                number of occupied entries (0..2)
module ita_oup_skid
   import ita_package::*;
#(
   parameter type T = oup_req_t
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  T           in_data_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output T           out_data_o,
   output logic [1:0] count_o
);

   logic out_valid_q, spare_valid_q;
   T     out_q, spare_q;
   logic push;

   // The spare entry only fills while the output entry is stalled, so
   // "spare empty" is exactly "room for one more beat next edge".
   assign in_ready_o = ~spare_valid_q;
   assign push       = in_valid_i & ~spare_valid_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q   <= 1'b0;
         spare_valid_q <= 1'b0;
         out_q         <= '0;
         spare_q       <= '0;
      end else begin
         if (!out_valid_q || out_ready_i) begin
            // Output slot is free this edge: refill from spare first to
            // keep order, otherwise take the incoming beat directly.
            if (spare_valid_q) begin
               out_valid_q   <= 1'b1;
               out_q         <= spare_q;
               spare_valid_q <= 1'b0;
            end else begin
               out_valid_q <= push;
               if (push) out_q <= in_data_i;
            end
         end else if (push) begin
            spare_valid_q <= 1'b1;
            spare_q       <= in_data_i;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_q;
   assign count_o     = spare_valid_q ? 2'd2 : (out_valid_q ? 2'd1 : 2'd0);

endmodule

// File: rtl/ita_oup_writer.sv
// Output writeback stage for the ITA requant FIFO.
//
// Accepts output beats in controller tile order (per MxM tile, M*M/N beats,
// tile_x fastest then tile_y), turns each into a byte-addressed write
// request with per-lane strobes, drops padding and signals completion.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i, cfg_base_i,
//   cfg_rows_i, cfg_cols_i        start pulse and matrix config (sampled in Idle)
//   in_valid_i/in_ready_o/in_data_i  beat input, valid/ready
//   mem_valid_o/mem_ready_i,
//   mem_addr_o/mem_data_o/mem_strb_o  write request output, valid/ready
//   busy_o                        high in Run and Drain
//   done_o                        one-cycle completion pulse
//   perf_stall_o, perf_drop_o     only with ITA_OUP_WRITER_PERF_EN defined
//
// Optional feature macro: ITA_OUP_WRITER_PERF_EN (stall/drop counters).
module ita_oup_writer
   import ita_package::*;
#(
   parameter int unsigned N         = OupN,
   parameter int unsigned M         = OupM,
   parameter int unsigned AddrWidth = OupAddrWidth,
   parameter int unsigned DimWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [AddrWidth-1:0] cfg_base_i,
   input  logic [DimWidth-1:0]  cfg_rows_i,
   input  logic [DimWidth-1:0]  cfg_cols_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [N*8-1:0]       in_data_i,
   output logic                 mem_valid_o,
   input  logic                 mem_ready_i,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [N*8-1:0]       mem_data_o,
   output logic [N-1:0]         mem_strb_o,
   output logic                 busy_o,
   output logic                 done_o
`ifdef ITA_OUP_WRITER_PERF_EN
   ,
   output logic [31:0]          perf_stall_o,
   output logic [31:0]          perf_drop_o
`endif
);

   localparam int unsigned BeatsPerTile = M * M / N;
   localparam int unsigned CntWidth     = $clog2(BeatsPerTile);
   localparam int unsigned LogM         = $clog2(M);
   localparam int unsigned LogN         = $clog2(N);
   localparam int unsigned ExtWidth     = DimWidth + 2;
   localparam int unsigned ProdWidth    = 2 * DimWidth;
   localparam logic [CntWidth-1:0] LastBeat = CntWidth'(BeatsPerTile - 1);

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [N*8-1:0]       data;
      logic [N-1:0]         strb;
   } req_t;

   oup_wr_state_e        state_q, state_d;
   logic [AddrWidth-1:0] base_q;
   logic [DimWidth-1:0]  rows_q, cols_q;
   logic [DimWidth-1:0]  tiles_x_q, tiles_y_q, tile_x_q, tile_y_q;
   logic [CntWidth-1:0]  beat_q;
   logic [DimWidth:0]    tiles_x_ext, tiles_y_ext;
   logic [ExtWidth-1:0]  grow, gcol;
   logic [ProdWidth-1:0] row_offset;
   logic [N-1:0]         strb;
   logic                 accept, push, last_beat, drain_done, skid_ready;
   logic [1:0]           skid_count;
   req_t                 req, mem_req;

   // Ceiling division by M, one extra bit so cols+M-1 cannot wrap.
   assign tiles_x_ext = ({1'b0, cfg_cols_i} + (DimWidth+1)'(M - 1)) >> LogM;
   assign tiles_y_ext = ({1'b0, cfg_rows_i} + (DimWidth+1)'(M - 1)) >> LogM;

   // Beat index within a tile: low log2(M) bits pick the row, the rest
   // pick the N-wide column group.
   assign grow = (ExtWidth'(tile_y_q) << LogM) + ExtWidth'(beat_q & CntWidth'(M - 1));
   assign gcol = (ExtWidth'(tile_x_q) << LogM) + (ExtWidth'(beat_q >> LogM) << LogN);

   always_comb begin
      strb = '0;
      for (int unsigned i = 0; i < N; i++) begin
         strb[i] = (grow < ExtWidth'(rows_q)) && ((gcol + ExtWidth'(i)) < ExtWidth'(cols_q));
      end
   end

   // Only beats with at least one enabled lane reach memory, and for those
   // grow < rows, so the low DimWidth bits of grow are exact.
   assign row_offset = ProdWidth'(grow[DimWidth-1:0]) * ProdWidth'(cols_q);

   always_comb begin
      req      = '0;
      req.addr = base_q + AddrWidth'(row_offset) + AddrWidth'(gcol);
      req.data = in_data_i;
      req.strb = strb;
   end

   assign in_ready_o = (state_q == Run) && skid_ready;
   assign accept     = in_valid_i && in_ready_o;
   assign push       = accept && (|strb);
   assign last_beat  = (beat_q == LastBeat)
                    && (tile_x_q == tiles_x_q - DimWidth'(1))
                    && (tile_y_q == tiles_y_q - DimWidth'(1));
   // Drain ends on the edge where the final entry leaves the buffer.
   assign drain_done = (skid_count == 2'd0) || ((skid_count == 2'd1) && mem_ready_i);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         Idle: begin
            if (start_i) begin
               state_d = ((cfg_rows_i != '0) && (cfg_cols_i != '0)) ? Run : Done;
            end
         end
         Run:     if (accept && last_beat) state_d = Drain;
         Drain:   if (drain_done) state_d = Done;
         Done:    state_d = Idle;
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= Idle;
         base_q    <= '0;
         rows_q    <= '0;
         cols_q    <= '0;
         tiles_x_q <= '0;
         tiles_y_q <= '0;
         tile_x_q  <= '0;
         tile_y_q  <= '0;
         beat_q    <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == Idle) && start_i) begin
            base_q    <= cfg_base_i;
            rows_q    <= cfg_rows_i;
            cols_q    <= cfg_cols_i;
            tiles_x_q <= DimWidth'(tiles_x_ext);
            tiles_y_q <= DimWidth'(tiles_y_ext);
            tile_x_q  <= '0;
            tile_y_q  <= '0;
            beat_q    <= '0;
         end else if (accept) begin
            if (beat_q == LastBeat) begin
               beat_q <= '0;
               if (tile_x_q == tiles_x_q - DimWidth'(1)) begin
                  tile_x_q <= '0;
                  tile_y_q <= tile_y_q + DimWidth'(1);
               end else begin
                  tile_x_q <= tile_x_q + DimWidth'(1);
               end
            end else begin
               beat_q <= beat_q + CntWidth'(1);
            end
         end
      end
   end

   ita_oup_skid #(
      .T (req_t)
   ) i_skid (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (push),
      .in_ready_o  (skid_ready),
      .in_data_i   (req),
      .out_valid_o (mem_valid_o),
      .out_ready_i (mem_ready_i),
      .out_data_o  (mem_req),
      .count_o     (skid_count)
   );

   assign mem_addr_o = mem_req.addr;
   assign mem_data_o = mem_req.data;
   assign mem_strb_o = mem_req.strb;
   assign busy_o     = (state_q == Run) || (state_q == Drain);
   assign done_o     = (state_q == Done);

`ifdef ITA_OUP_WRITER_PERF_EN
   logic [31:0] stall_q, drop_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
         drop_q  <= '0;
      end else if ((state_q == Idle) && start_i) begin
         stall_q <= '0;
         drop_q  <= '0;
      end else begin
         if (mem_valid_o && !mem_ready_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (accept && !(|strb) && (drop_q != '1))         drop_q  <= drop_q + 32'd1;
      end
   end

   assign perf_stall_o = stall_q;
   assign perf_drop_o  = drop_q;
`endif

endmodule

// File: tb/tb_ita_oup_writer.sv
// Directed bench for ita_oup_writer: full tile, padding, backpressure,
// degenerate config, mid-run reset and ignored start.
module tb_ita_oup_writer;
  import ita_package::*;

  localparam int N  = 16;
  localparam int M  = 64;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int W  = AW + N * 8 + N;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] cfg_base_i = '0;
  logic [DW-1:0] cfg_rows_i = '0;
  logic [DW-1:0] cfg_cols_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [N*8-1:0] in_data_i = '0;
  logic          mem_valid_o;
  logic          mem_ready_i = 1'b0;
  logic [AW-1:0] mem_addr_o;
  logic [N*8-1:0] mem_data_o;
  logic [N-1:0]  mem_strb_o;
  logic          busy_o;
  logic          done_o;
`ifdef ITA_OUP_WRITER_PERF_EN
  logic [31:0]   perf_stall_o;
  logic [31:0]   perf_drop_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] got_addr[$];
  logic [N-1:0]  got_strb[$];
  logic [AW-1:0] sav_addr[$];
  int ready_pct = 100;
  int cyc = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int exp_drops = 0;
  int feed_waits = 0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_req = '0;
  logic [W-1:0]  mon_e;

  ita_oup_writer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .cfg_base_i  (cfg_base_i),
    .cfg_rows_i  (cfg_rows_i),
    .cfg_cols_i  (cfg_cols_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_strb_o  (mem_strb_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef ITA_OUP_WRITER_PERF_EN
    ,
    .perf_stall_o (perf_stall_o),
    .perf_drop_o  (perf_drop_o)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      mem_ready_i = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [N*8-1:0] mk_data(input int seq, input int salt);
    logic [15:0] q, s;
    q = 16'(seq);
    s = 16'(salt);
    return {s, q, ~q, s ^ q, q + 16'h1111, s, 16'hA5C3, ~s};
  endfunction

  // Reference: walk the tiles in controller order and apply the
  // row/column validity rule lane by lane.
  task automatic build_exp(input logic [31:0] base, input int rows, input int cols,
                           input int salt, output int nbeats);
    int tx_n, ty_n, seq, grow, gcol;
    logic [N-1:0] s;
    logic [31:0]  a;
    exp_q.delete();
    exp_drops = 0;
    tx_n = (cols + M - 1) / M;
    ty_n = (rows + M - 1) / M;
    seq  = 0;
    for (int ty = 0; ty < ty_n; ty++)
      for (int tx = 0; tx < tx_n; tx++)
        for (int c = 0; c < M * M / N; c++) begin
          grow = ty * M + (c % M);
          gcol = tx * M + (c / M) * N;
          s = '0;
          for (int i = 0; i < N; i++)
            if (grow < rows && gcol + i < cols) s[i] = 1'b1;
          if (s != '0) begin
            a = base + 32'(grow * cols + gcol);
            exp_q.push_back({a, mk_data(seq, salt), s});
          end else begin
            exp_drops++;
          end
          seq++;
        end
    nbeats = seq;
  endtask

  task automatic clear_run();
    got_addr.delete();
    got_strb.delete();
    done_cnt    = 0;
    feed_waits  = 0;
    last_hs_cyc = 0;
    done_cyc    = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [31:0] base, input int rows, input int cols);
    start_i    = 1'b1;
    cfg_base_i = base;
    cfg_rows_i = 16'(rows);
    cfg_cols_i = 16'(cols);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Sends beats 0..min(nbeats,stop_after)-1; at beat mid_at also raises a
  // stray start_i with a different config.
  task automatic feed(input int nbeats, input int salt, input int stop_after,
                      input int mid_at, output int sent);
    int t;
    sent = 0;
    for (int s = 0; s < nbeats && s < stop_after; s++) begin
      t = 0;
      in_valid_i = 1'b1;
      in_data_i  = mk_data(s, salt);
      if (s == mid_at) begin
        start_i    = 1'b1;
        cfg_base_i = 32'hDEAD0000;
        cfg_rows_i = 16'd7;
        cfg_cols_i = 16'd0;
      end
      @(negedge clk_i);
      while (!in_ready_o && t < 2000) begin
        t++;
        @(negedge clk_i);
      end
      if (t >= 2000) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout got=%0d exp=%0d", sent, nbeats);
        in_valid_i = 1'b0;
        start_i    = 1'b0;
        return;
      end
      feed_waits += t;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      sent++;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk_i) begin
    cyc++;
    if (rst_ni) begin
      if (mem_valid_o && mem_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL req_extra got addr=%h exp=none", mem_addr_o);
        end else begin
          mon_e = exp_q.pop_front();
          if ({mem_addr_o, mem_data_o, mem_strb_o} !== mon_e) begin
            errors++;
            $display("FAIL req_match got addr=%h strb=%h data=%h exp addr=%h strb=%h data=%h",
                     mem_addr_o, mem_strb_o, mem_data_o,
                     mon_e[W-1 -: AW], mon_e[N-1:0], mon_e[N*8+N-1:N]);
          end
        end
        got_addr.push_back(mem_addr_o);
        got_strb.push_back(mem_strb_o);
        last_hs_cyc = cyc;
      end
      if (prev_stall) begin
        checks++;
        if (!mem_valid_o || {mem_addr_o, mem_data_o, mem_strb_o} !== prev_req) begin
          errors++;
          $display("FAIL req_hold got valid=%0b addr=%h exp valid=1 addr=%h",
                   mem_valid_o, mem_addr_o, prev_req[W-1 -: AW]);
        end
      end
      prev_stall = mem_valid_o && !mem_ready_i;
      prev_req   = {mem_addr_o, mem_data_o, mem_strb_o};
      checks++;
      if (in_ready_o && !busy_o) begin
        errors++;
        $display("FAIL ready_not_busy got in_ready=1 busy=0 exp in_ready=0");
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int nb, sent;
    logic [W-1:0] e;
    bit all_ff;
    bit same;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ctrl", 64'({in_ready_o, mem_valid_o, busy_o, done_o}), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_strb", 64'(mem_strb_o), 64'd0);
    chk("rst_data", 64'(|mem_data_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Full tile, no stalls.
    clear_run();
    ready_pct = 100;
    build_exp(32'h1000, 64, 64, 1, nb);
    chk("model_full_size", 64'(exp_q.size()), 64'd256);
    e = exp_q[0];
    chk("model_beat0", 64'(e[W-1 -: AW]), 64'h1000);
    e = exp_q[1];
    chk("model_beat1", 64'(e[W-1 -: AW]), 64'h1040);
    e = exp_q[64];
    chk("model_beat64", 64'(e[W-1 -: AW]), 64'h1010);
    do_start(32'h1000, 64, 64);
    feed(nb, 1, nb, -1, sent);
    wait_done(2000);
    chk("full_count", 64'(got_addr.size()), 64'd256);
    chk("full_addr0", 64'(got_addr[0]), 64'h1000);
    chk("full_addr1", 64'(got_addr[1]), 64'h1040);
    chk("full_addr64", 64'(got_addr[64]), 64'h1010);
    all_ff = 1'b1;
    foreach (got_strb[i]) if (got_strb[i] != 16'hFFFF) all_ff = 1'b0;
    chk("full_strb", 64'(all_ff), 64'd1);
    chk("full_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("full_done_cnt", 64'(done_cnt), 64'd1);
    chk("full_done_time", 64'(done_cyc - last_hs_cyc), 64'd1);
    chk("full_no_stall", 64'(feed_waits), 64'd0);
`ifdef ITA_OUP_WRITER_PERF_EN
    chk("perf_stall_zero", 64'(perf_stall_o), 64'd0);
`endif
    repeat (2) @(posedge clk_i);
    #1;

    // Padding: 50 x 70, two tiles wide.
    clear_run();
    build_exp(32'h4000, 50, 70, 2, nb);
    chk("model_pad_size", 64'(exp_q.size()), 64'd250);
    chk("model_pad_drops", 64'(exp_drops), 64'd262);
    do_start(32'h4000, 50, 70);
    feed(nb, 2, nb, -1, sent);
    wait_done(2000);
    chk("pad_count", 64'(got_addr.size()), 64'd250);
    chk("pad_tx1_strb", 64'(got_strb[200]), 64'h003F);
    chk("pad_tx1_addr0", 64'(got_addr[200]), 64'h4040);
    chk("pad_tx1_addr1", 64'(got_addr[201]), 64'h4086);
    chk("pad_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("pad_done_cnt", 64'(done_cnt), 64'd1);
`ifdef ITA_OUP_WRITER_PERF_EN
    chk("perf_drop", 64'(perf_drop_o), 64'd262);
`endif
    sav_addr = got_addr;
    repeat (2) @(posedge clk_i);
    #1;

    // Same padding job under random backpressure with a stray start mid-run.
    clear_run();
    ready_pct = 30;
    build_exp(32'h4000, 50, 70, 2, nb);
    do_start(32'h4000, 50, 70);
    feed(nb, 2, nb, 40, sent);
    wait_done(5000);
    chk("bp_count", 64'(got_addr.size()), 64'd250);
    chk("bp_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("bp_done_cnt", 64'(done_cnt), 64'd1);
    same = (got_addr.size() == sav_addr.size());
    if (same) foreach (got_addr[i]) if (got_addr[i] != sav_addr[i]) same = 1'b0;
    chk("bp_same_seq", 64'(same), 64'd1);
`ifdef ITA_OUP_WRITER_PERF_EN
    chk("perf_stall_nz", 64'(perf_stall_o != 0), 64'd1);
`endif
    ready_pct = 100;
    repeat (2) @(posedge clk_i);
    #1;

    // Degenerate: cols == 0.
    clear_run();
    exp_q.delete();
    do_start(32'h3000, 5, 0);
    @(negedge clk_i);
    chk("degen_done", 64'(done_o), 64'd1);
    chk("degen_ready", 64'({in_ready_o, busy_o}), 64'd0);
    @(negedge clk_i);
    chk("degen_done_pulse", 64'(done_o), 64'd0);
    repeat (3) @(negedge clk_i);
    chk("degen_no_req", 64'(got_addr.size()), 64'd0);
    chk("degen_done_cnt", 64'(done_cnt), 64'd1);
    @(posedge clk_i);
    #1;

    // Reset after 100 beats, then a clean run.
    clear_run();
    build_exp(32'h1000, 64, 64, 3, nb);
    do_start(32'h1000, 64, 64);
    feed(nb, 3, 100, -1, sent);
    chk("rst_mid_sent", 64'(sent), 64'd100);
    rst_ni = 1'b0;
    #2;
    chk("rst_mid_ctrl", 64'({in_ready_o, mem_valid_o, busy_o, done_o}), 64'd0);
    chk("rst_mid_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_mid_strb", 64'(mem_strb_o), 64'd0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
    exp_q.delete();
    clear_run();
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    build_exp(32'h2000, 64, 64, 4, nb);
    do_start(32'h2000, 64, 64);
    feed(nb, 4, nb, -1, sent);
    wait_done(2000);
    chk("rerun_addr0", 64'(got_addr[0]), 64'h2000);
    chk("rerun_count", 64'(got_addr.size()), 64'd256);
    chk("rerun_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("rerun_done_cnt", 64'(done_cnt), 64'd1);

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
